// File: rtl/bt_pkg.sv
// Shared definitions for the Bluetooth UART framing controllers (RX and TX side).
package bt_pkg;

    localparam int unsigned BT_IDLE_CYCLES = 500000;
    localparam int unsigned BT_LEN_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_PEND = 2'd2
    } bt_state_e;

endpackage

// File: rtl/bluetooth_frame_ctrl_if.sv
// Byte-stream, buffer-write and frame-handshake bundle of the RX framing controller.
interface bluetooth_frame_ctrl_if
    import bt_pkg::*;
#(
    parameter int unsigned LEN_W = BT_LEN_W
);
    logic             rx_done;
    logic [7:0]       rx_data;
    logic             wr_pulse;
    logic [LEN_W-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic             frame_valid;
    logic             frame_ready;
    logic [LEN_W-1:0] frame_len;
    logic             frame_ovf;
    logic             rx_drop;

    // The controller is the slave; the UART receiver / frame consumer side is the master.
    modport master (
        output rx_done, rx_data, frame_ready,
        input  wr_pulse, wr_addr, wr_data, frame_valid, frame_len, frame_ovf, rx_drop
    );

    modport slave (
        input  rx_done, rx_data, frame_ready,
        output wr_pulse, wr_addr, wr_data, frame_valid, frame_len, frame_ovf, rx_drop
    );
endinterface

// File: rtl/bt_idle_timer.sv
// Idle-gap timer: counts enabled cycles and flags the last one before wrap.
module bt_idle_timer
    import bt_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = BT_IDLE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int unsigned     CNT_W = $clog2(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IDLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // A clear in the same cycle suppresses expiry, so a late byte always wins the race.
    assign expire_o = en_i && !clr_i && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/bluetooth_frame_ctrl.sv
// Receive-side framing controller: byte strobes become addressed buffer writes and framed handshakes.
module bluetooth_frame_ctrl
    import bt_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = BT_IDLE_CYCLES,
    parameter int unsigned LEN_W       = BT_LEN_W,
    parameter int unsigned MAX_LEN     = 1024,
    parameter bit          TERM_EN     = 1'b0,
    parameter logic [7:0]  TERM_BYTE   = 8'h0A
) (
    input logic                   clk,
    input logic                   reset_n,
    bluetooth_frame_ctrl_if.slave bus
);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    bt_state_e        state_q;
    logic             rx_done_q;
    logic [LEN_W-1:0] len_cnt_q;
    logic             ovf_q;
    logic             wr_pulse_q;
    logic [LEN_W-1:0] wr_addr_q;
    logic [7:0]       wr_data_q;
    logic             frame_valid_q;
    logic             rx_drop_q;

    logic rx_edge;
    logic is_term;
    logic start_frame;
    logic idle_expire;

    assign rx_edge = bus.rx_done && !rx_done_q;
    assign is_term = TERM_EN && (bus.rx_data == TERM_BYTE);

    // A new frame opens from IDLE, or from PEND when the handshake completes in the edge cycle.
    assign start_frame = rx_edge &&
                         ((state_q == ST_IDLE) || ((state_q == ST_PEND) && bus.frame_ready));

    bt_idle_timer #(
        .IDLE_CYCLES(IDLE_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   ((state_q != ST_RECV) || rx_edge),
        .en_i    (state_q == ST_RECV),
        .expire_o(idle_expire)
    );

    // NOTE: all state below is updated with <= so every branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            rx_done_q     <= 1'b0;
            len_cnt_q     <= '0;
            ovf_q         <= 1'b0;
            wr_pulse_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_valid_q <= 1'b0;
            rx_drop_q     <= 1'b0;
        end else begin
            rx_done_q  <= bus.rx_done;
            wr_pulse_q <= 1'b0;
            rx_drop_q  <= 1'b0;
            if (start_frame) begin
                wr_pulse_q    <= 1'b1;
                wr_addr_q     <= '0;
                wr_data_q     <= bus.rx_data;
                len_cnt_q     <= LEN_W'(1);
                ovf_q         <= 1'b0;
                state_q       <= is_term ? ST_PEND : ST_RECV;
                frame_valid_q <= is_term;
            end else begin
                case (state_q)
                    ST_RECV: begin
                        if (rx_edge) begin
                            if (len_cnt_q < MAX_L) begin
                                wr_pulse_q <= 1'b1;
                                wr_addr_q  <= len_cnt_q;
                                wr_data_q  <= bus.rx_data;
                                len_cnt_q  <= len_cnt_q + 1'b1;
                                if (is_term) begin
                                    state_q       <= ST_PEND;
                                    frame_valid_q <= 1'b1;
                                end
                            end else begin
                                ovf_q     <= 1'b1;
                                rx_drop_q <= 1'b1;
                            end
                        end else if (idle_expire) begin
                            state_q       <= ST_PEND;
                            frame_valid_q <= 1'b1;
                        end
                    end
                    ST_PEND: begin
                        if (bus.frame_ready) begin
                            frame_valid_q <= 1'b0;
                            state_q       <= ST_IDLE;
                        end else if (rx_edge) begin
                            rx_drop_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.wr_pulse    = wr_pulse_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_len   = len_cnt_q;
    assign bus.frame_ovf   = ovf_q;
    assign bus.rx_drop     = rx_drop_q;
endmodule

// File: doc/bluetooth_frame_ctrl.md
# bluetooth_frame_ctrl

Parametrised receive-side framing controller for the Bluetooth UART path. It turns a stream of byte-received strobes into per-byte buffer writes with a frame-relative address. A frame closes on an idle gap or, optionally, on a terminator byte. Each completed frame is presented to the transmit side through a valid/ready handshake carrying its length and overflow flag.

## Interface
- `IDLE_CYCLES`, default 500000: idle clocks after the last accepted byte that close a frame; must be ≥ 2.
- `LEN_W`, default 16: width of the length and address fields.
- `MAX_LEN`, default 1024: maximum stored bytes per frame; must be ≥ 1 and < 2^LEN_W.
- `TERM_EN`, default 0: 1 enables terminator-byte frame close.
- `TERM_BYTE`, default 8'h0A: the terminator value.
- `clk`, input, 1: the single clock.
- `reset_n`, input, 1: synchronous, active-low reset.
- `rx_done`, input, 1: byte-received strobe from the UART receiver; may be high for one or more cycles.
- `rx_data`, input, 8: received byte, stable while `rx_done` is high.
- `wr_pulse`, output, 1: one-cycle buffer write enable.
- `wr_addr`, output, LEN_W: 0-based byte index within the frame.
- `wr_data`, output, 8: byte to write.
- `frame_valid`, output, 1: a completed frame is pending.
- `frame_ready`, input, 1: the consumer accepts the frame.
- `frame_len`, output, LEN_W: number of stored bytes; valid while `frame_valid` is high.
- `frame_ovf`, output, 1: more than MAX_LEN bytes arrived; valid while `frame_valid` is high.
- `rx_drop`, output, 1: one-cycle pulse when a byte is discarded.

## Operation
- **Byte acceptance:** a byte is accepted on a rising edge of `rx_done`, detected as `rx_done` high with its 1-cycle delayed copy low. A multi-cycle `rx_done` yields exactly one byte.
- **IDLE state:**
  - An edge writes the byte at address 0, sets `len_cnt` to 1, and moves to RECV.
- **RECV state:**
  - An edge with `len_cnt < MAX_LEN` writes at address `len_cnt`, increments `len_cnt`, and clears `idle_cnt`.
  - An edge with `len_cnt == MAX_LEN` sets the sticky overflow flag, pulses `rx_drop`, performs no write, and clears `idle_cnt`.
  - A cycle with no edge increments `idle_cnt`. When `idle_cnt == IDLE_CYCLES-1`, the state moves to PEND.
  - With `TERM_EN=1`, an accepted and written byte equal to `TERM_BYTE` moves to PEND in the same cycle as its write. The terminator is counted in the length.
- **PEND state:**
  - `frame_valid` is 1, and `frame_len`/`frame_ovf` are held.
  - `frame_valid && frame_ready` completes the handshake.
  - If there is no edge in the handshake cycle, the state moves to IDLE.
  - If there is an edge in the handshake cycle, that byte starts a new frame: it is written at address 0, `len_cnt` becomes 1, and the state moves to RECV.
  - An edge without `frame_ready` is dropped and pulses `rx_drop`.
- **Simultaneous events:** a byte edge in the same cycle that `idle_cnt` reaches its limit wins. The byte is accepted and the timer restarts.
- **Width rules:** `len_cnt` is LEN_W bits and saturates at MAX_LEN, so it never wraps. `idle_cnt` is `$clog2(IDLE_CYCLES)` bits.

## Timing
- **Reset values:** `reset_n` low at a clock edge sets all outputs, counters, the overflow flag and the edge register to 0, and the state to IDLE. This applies mid-frame as well: the partial frame is discarded with no `frame_valid`.
- **Write latency:** byte edge sampled at cycle t gives `wr_pulse`/`wr_addr`/`wr_data` at t+1. The outputs are registered.
- **Idle close:** last accepted edge at cycle t gives `frame_valid` rising at t+IDLE_CYCLES+1.
- **Terminator close:** terminator edge at t gives `wr_pulse` and `frame_valid` both at t+1.
- **Drop pulse:** `rx_drop` is asserted at t+1 for a drop decided at t.
- **Handshake:** `frame_valid` falls the cycle after the handshake cycle. `frame_len`/`frame_ovf` hold their values until then.

## Structure
- **Shared package `bt_pkg`:**
  - state encoding: IDLE=2'd0, RECV=2'd1, PEND=2'd2
  - default constants for IDLE_CYCLES and LEN_W, shared with the Bluetooth TX controller
- **Sub-module `bt_idle_timer`:**
  - inputs: clear, enable
  - output: a one-cycle expire at count IDLE_CYCLES-1
- Edge detect, length counter and FSM stay in the top module.

## Test plan
- **Basic frame:** IDLE_CYCLES=100; edges at cycles 10, 30, 50 with bytes 8'h41, 8'h42, 8'h43 → `wr_addr` 0, 1, 2 at cycles 11, 31, 51; `frame_valid` at 151 with `frame_len`=3, `frame_ovf`=0.
- **Long strobe and timer race:** `rx_done` held 5 cycles → a single `wr_pulse`. Then an edge exactly on the `idle_cnt` limit cycle → byte accepted and frame still open.
- **Terminator:** TERM_EN=1; bytes 8'h31, 8'h0A → `frame_valid` the cycle after the 8'h0A edge, with `frame_len`=2.
- **Overflow:** MAX_LEN=4; 6 bytes → 4 writes (addresses 0–3), 2 `rx_drop` pulses, `frame_len`=4, `frame_ovf`=1.
- **Backpressure:**
  - `frame_ready` held low for 50 cycles with an edge during PEND → `rx_drop` pulse and `frame_len` unchanged.
  - `frame_ready` high in the same cycle as an edge → new frame starts with `wr_addr`=0.
- **Mid-frame reset:** `reset_n` low for 1 cycle after 2 bytes → all outputs 0. The next byte is written at address 0, and the next frame reports `frame_len`=1.
